// File: rtl/cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cache_ctrl_fsm
//
// Sequencing controller for the 8-way tag memory of one cache slice. It takes
// one CPU access at a time and walks it through tag lookup, an optional
// dirty-victim writeback, the line fill, the tag update and the LRU aging
// step, then returns a one-cycle completion pulse to the CPU.
//
// Optional feature: define CACHE_STATS_EN to add the saturating 16-bit
// hit/miss counters (stat_hits_o, stat_misses_o). Without the macro the ports
// and counters do not exist and the controller behaves identically.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cpu_req_i         access request, accepted when cpu_req_i & cpu_ready_o
//   cpu_we_i          1 = write, 0 = read, sampled with the request
//   cpu_addr_i        {tag,index,offset}, sampled with the request
//   cpu_ready_o       controller idle and able to accept
//   cpu_ack_o         one-cycle completion pulse
//   cpu_hit_o         valid with cpu_ack_o: 1 = the access hit
//   line_chan_o       way holding the current line (data array select)
//   tm_tag_o          latched address tag presented to the tag memory
//   tm_index_o        latched set index presented to the tag memory
//   tm_wr_o           tag write strobe
//   tm_mod_in_o       dirty bit written with tm_wr_o
//   tm_age_o          LRU age strobe (marks the hitting way most recent)
//   tm_hit_i          tag-memory hit for tm_tag_o/tm_index_o
//   tm_chan_i         way that hit
//   tm_age_chan_i     LRU victim way of the set
//   tm_age_tag_i      tag stored in the victim way
//   tm_age_mod_i      victim way is dirty
//   mem_req_o         backing-memory request, held until mem_ack_i
//   mem_we_o          1 = writeback, 0 = fill
//   mem_addr_o        line address, offset bits zero
//   mem_ack_i         one-cycle completion from backing memory
//   state_o           current FSM state, for debug and checkers
//   stat_hits_o       (CACHE_STATS_EN) completed hits, saturating
//   stat_misses_o     (CACHE_STATS_EN) completed misses, saturating
//
// Handshakes
//   CPU side: a transfer happens on a rising edge where cpu_req_i and
//   cpu_ready_o are both high; a request seen while cpu_ready_o is low is
//   ignored and the requester must keep it up. Memory side: mem_req_o,
//   mem_we_o and mem_addr_o rise together and stay constant until the edge
//   that samples mem_ack_i high; mem_ack_i outside a request is ignored.
// ---------------------------------------------------------------------------
module cache_ctrl_fsm #(
  parameter int TAG_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int CHAN_WIDTH   = 3,
  localparam int ADDR_W      = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // CPU port
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_W-1:0]       cpu_addr_i,
  output logic                    cpu_ready_o,
  output logic                    cpu_ack_o,
  output logic                    cpu_hit_o,
  // tag memory / line buffer
  output logic [CHAN_WIDTH-1:0]   line_chan_o,
  output logic [TAG_WIDTH-1:0]    tm_tag_o,
  output logic [INDEX_WIDTH-1:0]  tm_index_o,
  output logic                    tm_wr_o,
  output logic                    tm_mod_in_o,
  output logic                    tm_age_o,
  input  logic                    tm_hit_i,
  input  logic [CHAN_WIDTH-1:0]   tm_chan_i,
  input  logic [CHAN_WIDTH-1:0]   tm_age_chan_i,
  input  logic [TAG_WIDTH-1:0]    tm_age_tag_i,
  input  logic                    tm_age_mod_i,
  // backing memory
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_ack_i,
`ifdef CACHE_STATS_EN
  output logic [15:0]             stat_hits_o,
  output logic [15:0]             stat_misses_o,
`endif
  // debug
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WBACK  = 3'd2,
    FILL   = 3'd3,
    UPDATE = 3'd4,
    AGE    = 3'd5,
    RESP   = 3'd6
  } state_e;

  state_e                   state_q;

  // Latched request
  logic                     we_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [INDEX_WIDTH-1:0]   index_q;

  // Registered outputs
  logic                     cpu_ready_q;
  logic                     cpu_ack_q;
  logic                     cpu_hit_q;
  logic [CHAN_WIDTH-1:0]    line_chan_q;
  logic                     upd_wr_q;
  logic                     age_q;
  logic                     mem_req_q;
  logic                     mem_we_q;
  logic [ADDR_W-1:0]        mem_addr_q;

`ifdef CACHE_STATS_EN
  logic [15:0]              stat_hits_q;
  logic [15:0]              stat_misses_q;
`endif

  // The line offset never reaches the tag path; only tag and index are kept.
  logic                     unused_offset;
  assign unused_offset = ^cpu_addr_i[OFFSET_WIDTH-1:0];

  localparam logic [OFFSET_WIDTH-1:0] OFFSET_ZERO = '0;

  // A hit in LOOKUP must age the way (and mark it dirty on a write) in that
  // same cycle, while the tag memory is still presenting the hit. Those
  // strobes therefore combine the registered UPDATE/AGE strobes with the
  // LOOKUP-cycle hit term. The dirty bit written always equals the latched
  // write flag: a write hit sets it, and a fill stores cpu_we.
  logic lookup_hit;
  assign lookup_hit = (state_q == LOOKUP) && tm_hit_i;

  assign tm_age_o    = age_q | lookup_hit;
  assign tm_wr_o     = upd_wr_q | (lookup_hit & we_q);
  assign tm_mod_in_o = tm_wr_o & we_q;

  assign cpu_ready_o = cpu_ready_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_hit_o   = cpu_hit_q;
  assign line_chan_o = line_chan_q;
  assign tm_tag_o    = tag_q;
  assign tm_index_o  = index_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign state_o     = state_q;

`ifdef CACHE_STATS_EN
  assign stat_hits_o   = stat_hits_q;
  assign stat_misses_o = stat_misses_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Asynchronous clear: an in-flight fill is abandoned and mem_req
      // drops immediately; no completion is reported for it.
      state_q       <= IDLE;
      we_q          <= 1'b0;
      tag_q         <= '0;
      index_q       <= '0;
      cpu_ready_q   <= 1'b1;
      cpu_ack_q     <= 1'b0;
      cpu_hit_q     <= 1'b0;
      line_chan_q   <= '0;
      upd_wr_q      <= 1'b0;
      age_q         <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
`ifdef CACHE_STATS_EN
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
`endif
    end else begin
      // Single-cycle strobes default low so each lasts exactly one step.
      cpu_ack_q <= 1'b0;
      cpu_hit_q <= 1'b0;
      upd_wr_q  <= 1'b0;
      age_q     <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            we_q        <= cpu_we_i;
            tag_q       <= cpu_addr_i[ADDR_W-1 -: TAG_WIDTH];
            index_q     <= cpu_addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
            cpu_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (tm_hit_i) begin
            line_chan_q <= tm_chan_i;
            cpu_ack_q   <= 1'b1;
            cpu_hit_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            // The victim way becomes the line's home. Its tag is only needed
            // for the writeback address, which is formed right here so the
            // request goes out fully registered on the next cycle.
            line_chan_q <= tm_age_chan_i;
            mem_req_q   <= 1'b1;
            if (tm_age_mod_i) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= {tm_age_tag_i, index_q, OFFSET_ZERO};
              state_q    <= WBACK;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag_q, index_q, OFFSET_ZERO};
              state_q    <= FILL;
            end
          end
        end

        WBACK: begin
          // mem_req stays high straight into the fill request.
          if (mem_ack_i) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag_q, index_q, OFFSET_ZERO};
            state_q    <= FILL;
          end
        end

        FILL: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            upd_wr_q  <= 1'b1;
            state_q   <= UPDATE;
          end
        end

        UPDATE: begin
          // Tag written this cycle; the new line hits from the next cycle,
          // which is when AGE makes it most recently used.
          age_q   <= 1'b1;
          state_q <= AGE;
        end

        AGE: begin
          cpu_ack_q <= 1'b1;
          cpu_hit_q <= 1'b0;
          state_q   <= RESP;
        end

        RESP: begin
`ifdef CACHE_STATS_EN
          if (cpu_hit_q) begin
            if (stat_hits_q != 16'hFFFF) stat_hits_q <= stat_hits_q + 16'd1;
          end else begin
            if (stat_misses_q != 16'hFFFF) stat_misses_q <= stat_misses_q + 16'd1;
          end
`endif
          cpu_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: begin
          cpu_ready_q <= 1'b1;
          mem_req_q   <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
